// File: rtl/drum_audio_sink.sv
// drum_audio_sink: consumer end of the drum mesh output interface.
// Solver samples (signed 1.17) are queued in a small circular FIFO. Each
// sample is scaled to a 32-bit audio word and sent to the codec twice, as a
// left/right pair. The codec's back-pressure reaches the solver via sample_ready.
// Optional feature macro: DRUM_AUDIO_SINK_PEAK_EN adds a peak |sample| tracker
// with the ports peak_clear and peak_abs.
module drum_audio_sink #(
  parameter int DEPTH = 8,
  parameter int SHIFT = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [17:0]             sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [31:0]             audio_data,
  output logic                    audio_valid,
  output logic                    audio_channel,
  input  logic                    audio_ready,
  output logic [$clog2(DEPTH):0]  fill_level
`ifdef DRUM_AUDIO_SINK_PEAK_EN
  ,
  input  logic                    peak_clear,
  output logic [17:0]             peak_abs
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_L = 2'd1,
    SEND_R = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [17:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              sample_ready_r;
  logic              audio_valid_r;
  logic              audio_channel_r;
  logic [31:0]       hold_r;
  logic              wr_s;
  logic              pop_s;

  // Sign-extend an 18-bit sample to 32 bits, then scale it by SHIFT.
  function automatic logic [31:0] to_audio(input logic [17:0] s);
    logic [31:0] ext;
    ext = {{(32-18){s[17]}}, s};
    return ext << SHIFT;
  endfunction

  // sample_ready_r tracks (count_r != DEPTH), so the write decode uses only registered state.
  assign wr_s = sample_valid && sample_ready_r;

  // Output FSM: pop into the hold register and walk through the L/R pair.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          pop_s        = 1'b1;
          state_next_s = SEND_L;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND_L: begin
        if (audio_ready) begin
          state_next_s = SEND_R;
        end else begin
          state_next_s = SEND_L;
        end
      end
      SEND_R: begin
        if (audio_ready) begin
          if (count_r != {CNT_W{1'b0}}) begin
            pop_s        = 1'b1;
            state_next_s = SEND_L;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = SEND_R;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Occupancy update. A write and a pop in the same cycle cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Control state, pointers, hold register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      count_r         <= {CNT_W{1'b0}};
      wr_ptr_r        <= {PTR_W{1'b0}};
      rd_ptr_r        <= {PTR_W{1'b0}};
      sample_ready_r  <= 1'b1;
      audio_valid_r   <= 1'b0;
      audio_channel_r <= 1'b0;
      hold_r          <= 32'd0;
    end else begin
      state_r         <= state_next_s;
      count_r         <= count_next_s;
      sample_ready_r  <= (count_next_s != FULL_LVL);
      audio_valid_r   <= (state_next_s != IDLE);
      audio_channel_r <= (state_next_s == SEND_R);
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        hold_r   <= to_audio(mem_r[rd_ptr_r]);
      end
    end
  end

  // Sample storage. It needs no reset because the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= sample_in;
    end
  end

  assign sample_ready  = sample_ready_r;
  assign audio_valid   = audio_valid_r;
  assign audio_channel = audio_channel_r;
  assign audio_data    = hold_r;
  assign fill_level    = count_r;

`ifdef DRUM_AUDIO_SINK_PEAK_EN
  logic [17:0] peak_r;

  // Magnitude of a signed 18-bit sample. The most negative code saturates to +max.
  function automatic logic [17:0] abs_sat(input logic [17:0] s);
    logic [17:0] r;
    if (s == 18'h20000) begin
      r = 18'h1FFFF;
    end else if (s[17]) begin
      r = 18'd0 - s;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Peak tracker over accepted writes. On a clear, a coincident write restarts the peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_r <= 18'd0;
    end else if (peak_clear) begin
      peak_r <= wr_s ? abs_sat(sample_in) : 18'd0;
    end else if (wr_s && (abs_sat(sample_in) > peak_r)) begin
      peak_r <= abs_sat(sample_in);
    end
  end

  assign peak_abs = peak_r;
`endif

endmodule
